// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: round-robin arbiter sharing the single register-file port
// between N requesters (index 0 = core), one access per req/gnt handshake.
//
// Optional feature macro: REGARB_R0_PROTECT_EN
//   defined   -> writes to address 0 from requesters other than 0 are dropped
//                (rf_we held low) and err[winner] pulses alongside gnt.
//   undefined -> all writes pass, err is tied low.
//
// Ports:
//   clk        in   clock, all state on posedge
//   reset      in   synchronous active-high reset
//   req        in   [N]    per-requester request, held until gnt
//   req_we     in   [N]    1 = write, 0 = read
//   req_addr   in   [N*D]  packed addresses, requester i at [i*D +: D]
//   req_wdata  in   [N*W]  packed write data, requester i at [i*W +: W]
//   gnt        out  [N]    one-hot pulse during the access cycle
//   rvalid     out  [N]    one-hot pulse the cycle after a read access
//   rdata      out  [W]    registered read data, shared
//   err        out  [N]    one-hot pulse with gnt on a suppressed write
//   rf_addr    out  [D]    register-file address
//   rf_we      out  1      register-file write enable
//   rf_wdata   out  [W]    register-file write data
//   rf_rdata   in   [W]    register-file combinational read data

module reg_port_arbiter #(
    parameter int W = 8,
    parameter int D = 4,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   req_we,
    input  logic [N*D-1:0] req_addr,
    input  logic [N*W-1:0] req_wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rvalid,
    output logic [W-1:0]   rdata,
    output logic [N-1:0]   err,
    output logic [D-1:0]   rf_addr,
    output logic           rf_we,
    output logic [W-1:0]   rf_wdata,
    input  logic [W-1:0]   rf_rdata
);

    localparam int IW = (N > 2) ? 2 : 1;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_win;
    logic          r_we;
    logic [D-1:0]  r_addr;
    logic [W-1:0]  r_wdata;
    logic [W-1:0]  r_rdata;
    logic [N-1:0]  r_rvalid;

    logic [IW-1:0] w_cand [N];
    logic          w_found;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_next;
    logic [N-1:0]  w_onehot;
    logic          w_acc;
    logic          w_supp;

    // Candidate order starts at the pointer and wraps modulo N, so the
    // first requesting candidate is the round-robin winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand[k] = IW'((int'(r_ptr) + k) % N);
        end
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[w_cand[k]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[k];
            end
        end
    end

    assign w_next   = IW'((int'(r_win) + 1) % N);
    assign w_onehot = {{(N-1){1'b0}}, 1'b1} << r_win;

    // Reset during the access cycle must kill the strobe in that same
    // cycle, so the access qualifier looks at reset combinationally.
    assign w_acc = (r_state == S_ACCESS) && !reset;

`ifdef REGARB_R0_PROTECT_EN
    assign w_supp = r_we && (r_addr == '0) && (r_win != '0);
`else
    assign w_supp = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win   <= w_pick;
                        r_we    <= req_we[w_pick];
                        r_addr  <= req_addr[int'(w_pick)*D +: D];
                        r_wdata <= req_wdata[int'(w_pick)*W +: W];
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_rdata  <= rf_rdata;
                        r_rvalid <= w_onehot;
                    end
                    r_ptr   <= w_next;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt      = w_acc ? w_onehot : '0;
    assign err      = (w_acc && w_supp) ? w_onehot : '0;
    assign rf_we    = w_acc && r_we && !w_supp;
    assign rf_addr  = r_addr;
    assign rf_wdata = r_wdata;
    assign rdata    = r_rdata;
    // A reset in the cycle after a read swallows the pending rvalid.
    assign rvalid   = reset ? '0 : r_rvalid;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb_reg_port_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the arbiter and register file.

module tb_reg_port_arbiter;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 2;

`ifdef REGARB_R0_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   req_we;
    logic [N*D-1:0] req_addr;
    logic [N*W-1:0] req_wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rvalid;
    logic [W-1:0]   rdata;
    logic [N-1:0]   err;
    logic [D-1:0]   rf_addr;
    logic           rf_we;
    logic [W-1:0]   rf_wdata;
    logic [W-1:0]   rf_rdata;

    logic [W-1:0]   mem [16];
    logic           pl_en;
    logic [D-1:0]   pl_a;
    logic [W-1:0]   pl_d;

    int checks = 0;
    int errors = 0;

    reg_port_arbiter #(.W(W), .D(D), .N(N)) dut (
        .clk(clk), .reset(reset),
        .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .rf_addr(rf_addr), .rf_we(rf_we),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file behind the port, with a side door for preloading.
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (rf_we) mem[rf_addr] <= rf_wdata;
    end
    assign rf_rdata = mem[rf_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic setreq(input int i, input bit r, input bit we,
                          input logic [D-1:0] a, input logic [W-1:0] d);
        req[i] = r;
        req_we[i] = we;
        req_addr[i*D +: D] = a;
        req_wdata[i*W +: W] = d;
    endtask

    task automatic preload(input logic [D-1:0] a, input logic [W-1:0] d);
        pl_en = 1'b1;
        pl_a = a;
        pl_d = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Randomized-phase model state
    logic [W-1:0] m_mem [16];
    int           m_ptr;
    bit           m_acc;
    int           m_win;
    bit           m_we;
    logic [D-1:0] m_a;
    logic [W-1:0] m_d;
    bit           m_rv;
    int           m_rvw;
    logic [W-1:0] m_rvd;
    bit           r_act [N];
    bit           r_we [N];
    logic [D-1:0] r_a [N];
    logic [W-1:0] r_d [N];
    logic [N-1:0] lastgnt;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_err;
    logic [N-1:0] e_rv;
    bit           e_we;
    bit           sup;
    bit           found;

    initial begin
        reset = 1'b1;
        req = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        pl_en = 1'b0;
        pl_a = '0;
        pl_d = '0;
        tick();
        tick();
        for (int i = 0; i < 16; i++) preload(D'(i), W'(i));
        preload(4'd5, 8'h3C);
        preload(4'd3, 8'h11);
        preload(4'd0, 8'h99);
        settle();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_rf_addr", 32'(rf_addr), 0);
        chk("rst_rf_wdata", 32'(rf_wdata), 0);

        // Single read by requester 1
        tick(); reset = 1'b0; setreq(1, 1, 0, 4'd5, 8'h00); settle();
        chk("t1_idle_gnt", 32'(gnt), 0);
        tick(); settle();
        chk("t1_gnt", 32'(gnt), 32'b10);
        chk("t1_rf_addr", 32'(rf_addr), 5);
        chk("t1_rf_we", 32'(rf_we), 0);
        tick(); setreq(1, 0, 0, 4'd5, 8'h00); settle();
        chk("t1_rvalid", 32'(rvalid), 32'b10);
        chk("t1_rdata", 32'(rdata), 32'h3C);
        chk("t1_gnt_off", 32'(gnt), 0);

        // Write by requester 0, read back by requester 1
        tick(); setreq(0, 1, 1, 4'd9, 8'hA7); settle();
        tick(); settle();
        chk("t2_gnt", 32'(gnt), 32'b01);
        chk("t2_rf_we", 32'(rf_we), 1);
        chk("t2_rf_addr", 32'(rf_addr), 9);
        chk("t2_rf_wdata", 32'(rf_wdata), 32'hA7);
        tick(); setreq(0, 0, 0, 4'd9, 8'h00); setreq(1, 1, 0, 4'd9, 8'h00);
        settle();
        chk("t2_rf_we_once", 32'(rf_we), 0);
        chk("t2_mem9", 32'(mem[9]), 32'hA7);
        chk("t2_no_rvalid", 32'(rvalid), 0);
        tick(); settle();
        chk("t2_gnt1", 32'(gnt), 32'b10);
        tick(); setreq(1, 0, 0, 4'd9, 8'h00); settle();
        chk("t2_rvalid", 32'(rvalid), 32'b10);
        chk("t2_rdata", 32'(rdata), 32'hA7);

        // Full contention straight out of reset
        tick(); reset = 1'b1;
        setreq(0, 1, 0, 4'd1, 8'h00); setreq(1, 1, 0, 4'd2, 8'h00); settle();
        for (int k = 1; k <= 8; k++) begin
            tick(); reset = 1'b0; settle();
            if (k % 2 == 1) chk("t3_gap", 32'(gnt), 0);
            else if ((k / 2) % 2 == 1) chk("t3_gnt0", 32'(gnt), 32'b01);
            else chk("t3_gnt1", 32'(gnt), 32'b10);
        end
        tick(); setreq(0, 0, 0, 4'd1, 8'h00); setreq(1, 0, 0, 4'd2, 8'h00);
        settle();
        chk("t3_rvalid", 32'(rvalid), 32'b10);
        chk("t3_rdata", 32'(rdata), 32'h02);

        // Reset during the access cycle of a write
        tick(); setreq(0, 1, 1, 4'd3, 8'hFF); settle();
        tick(); reset = 1'b1; setreq(0, 0, 0, 4'd3, 8'h00); settle();
        chk("t4_gnt", 32'(gnt), 0);
        chk("t4_rf_we", 32'(rf_we), 0);
        chk("t4_err", 32'(err), 0);
        tick(); reset = 1'b0; settle();
        chk("t4_mem3", 32'(mem[3]), 32'h11);
        chk("t4_idle", 32'(gnt), 0);
        tick(); setreq(0, 1, 0, 4'd4, 8'h00); setreq(1, 1, 0, 4'd6, 8'h00);
        settle();
        chk("t4_sample", 32'(gnt), 0);
        tick(); setreq(0, 0, 0, 4'd4, 8'h00); setreq(1, 0, 0, 4'd6, 8'h00);
        settle();
        chk("t4_ptr0", 32'(gnt), 32'b01);
        tick(); settle();
        chk("t4_rvalid", 32'(rvalid), 32'b01);
        chk("t4_rdata", 32'(rdata), 32'h04);

        // Writes to address 0
        tick(); setreq(1, 1, 1, 4'd0, 8'h55); settle();
        tick(); settle();
        chk("t5_gnt1", 32'(gnt), 32'b10);
        chk("t5_err1", 32'(err), PROT ? 32'b10 : 32'b00);
        chk("t5_we1", 32'(rf_we), PROT ? 32'd0 : 32'd1);
        tick(); setreq(1, 0, 0, 4'd0, 8'h00); settle();
        chk("t5_mem0_r1", 32'(mem[0]), PROT ? 32'h99 : 32'h55);
        chk("t5_err_off", 32'(err), 0);
        tick(); setreq(0, 1, 1, 4'd0, 8'h55); settle();
        tick(); settle();
        chk("t5_gnt0", 32'(gnt), 32'b01);
        chk("t5_err0", 32'(err), 0);
        chk("t5_we0", 32'(rf_we), 1);
        tick(); setreq(0, 0, 0, 4'd0, 8'h00); settle();
        chk("t5_mem0_r0", 32'(mem[0]), 32'h55);

        // Requester 1 pulses req only during requester 0's access
        tick(); setreq(0, 1, 0, 4'd4, 8'h00); settle();
        tick(); setreq(1, 1, 0, 4'd7, 8'h00); settle();
        chk("t6_gnt0", 32'(gnt), 32'b01);
        tick(); setreq(0, 0, 0, 4'd4, 8'h00); setreq(1, 0, 0, 4'd7, 8'h00);
        settle();
        chk("t6_rvalid", 32'(rvalid), 32'b01);
        chk("t6_gnt_a", 32'(gnt), 0);
        tick(); settle();
        chk("t6_gnt_b", 32'(gnt), 0);
        chk("t6_rf_we", 32'(rf_we), 0);
        tick(); settle();
        chk("t6_gnt_c", 32'(gnt), 0);

        // Reset in the cycle after a read access hides rvalid
        tick(); setreq(1, 1, 0, 4'd5, 8'h00); settle();
        tick(); settle();
        chk("t7_gnt", 32'(gnt), 32'b10);
        tick(); setreq(1, 0, 0, 4'd5, 8'h00); reset = 1'b1; settle();
        chk("t7_rvalid_rst", 32'(rvalid), 0);
        tick(); reset = 1'b0; settle();
        chk("t7_rvalid_after", 32'(rvalid), 0);

        // Randomized traffic against the transaction model
        tick(); reset = 1'b1; req = '0;
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = W'(i * 29) ^ 8'h5A;
            preload(D'(i), m_mem[i]);
        end
        m_ptr = 0; m_acc = 0; m_rv = 0; m_win = 0; m_rvw = 0;
        m_we = 0; m_a = '0; m_d = '0; m_rvd = '0;
        lastgnt = '0;
        for (int i = 0; i < N; i++) begin
            r_act[i] = 0; r_we[i] = 0; r_a[i] = '0; r_d[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            tick();
            reset = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (lastgnt[i]) r_act[i] = 0;
                if (!r_act[i] && $urandom_range(0, 2) == 0) begin
                    r_act[i] = 1;
                    r_we[i] = 1'($urandom_range(0, 1));
                    r_a[i] = D'($urandom_range(0, 15));
                    r_d[i] = W'($urandom);
                end
                setreq(i, r_act[i], r_we[i], r_a[i], r_d[i]);
            end
            settle();
            e_gnt = '0; e_err = '0; e_rv = '0; e_we = 0;
            if (m_rv) e_rv[m_rvw] = 1'b1;
            chk("rnd_rvalid", 32'(rvalid), 32'(e_rv));
            if (m_rv) chk("rnd_rdata", 32'(rdata), 32'(m_rvd));
            m_rv = 0;
            if (m_acc) begin
                e_gnt[m_win] = 1'b1;
                sup = PROT && m_we && (m_a == '0) && (m_win != 0);
                if (sup) e_err = e_gnt;
                if (m_we && !sup) begin
                    e_we = 1;
                    m_mem[m_a] = m_d;
                end
                if (!m_we) begin
                    m_rv = 1;
                    m_rvw = m_win;
                    m_rvd = m_mem[m_a];
                end
                chk("rnd_rf_addr", 32'(rf_addr), 32'(m_a));
                m_ptr = (m_win + 1) % N;
                m_acc = 0;
            end else begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found = 1;
                        m_win = (m_ptr + k) % N;
                        m_we = r_we[m_win];
                        m_a = r_a[m_win];
                        m_d = r_d[m_win];
                        m_acc = 1;
                    end
                end
            end
            chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
            chk("rnd_err", 32'(err), 32'(e_err));
            chk("rnd_rf_we", 32'(rf_we), 32'(e_we));
            lastgnt = gnt;
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
